prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader_byte_assembler.sv | 34 +++
 rtl/prog_loader.sv | 128 ++++++++++++
 tb/tb_prog_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the serial program loader.
package prog_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;
    // The header carries a little-endian word count of this many bytes.
    localparam int unsigned HDR_BYTES  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Packs four serial bytes into one little-endian instruction word.
module byte_assembler
    import prog_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [7:0]            byte_in,
    output logic [DATA_W_DEF-1:0] word,
    output logic                  word_full
);

    logic [1:0]            cnt_q;
    logic [DATA_W_DEF-1:0] shift_q;

    // Shift bytes in from the top so the first byte ends up in bits 7:0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear) begin
            cnt_q   <= '0;
        end else if (byte_en) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_in, shift_q[DATA_W_DEF-1:8]};
        end
    end

    assign word      = shift_q;
    // High on the cycle the fourth byte is accepted.
    assign word_full = byte_en && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CountW = HDR_BYTES * 8;
    // One extra bit so a full memory (2^ADDR_W words) is representable.
    localparam logic [CountW:0] MaxWords = (CountW + 1)'(64'd1 << ADDR_W);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          cnt_lo_q, cnt_lo_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [CountW-1:0]   hdr_count;
    logic                accept;
    logic                asm_clear;
    logic                word_full;
    logic [DATA_W_DEF-1:0] asm_word;

    assign accept    = byte_valid && byte_ready;
    assign hdr_count = {byte_in, cnt_lo_q};

    byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .byte_en   (accept && (state_q == StData)),
        .byte_in   (byte_in),
        .word      (asm_word),
        .word_full (word_full)
    );

    // State, word index and header count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_lo_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_lo_q <= cnt_lo_d;
            count_q  <= count_d;
        end
    end

    // Next-state logic: header parse, word collection and one-cycle writes.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_lo_d  = cnt_lo_q;
        count_d   = count_q;
        asm_clear = 1'b0;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d   = StHdr0;
                    idx_d     = '0;
                    asm_clear = 1'b1;
                end
            end
            StHdr0: begin
                if (accept) begin
                    cnt_lo_d = byte_in;
                    state_d  = StHdr1;
                end
            end
            StHdr1: begin
                if (accept) begin
                    count_d = hdr_count;
                    if ({1'b0, hdr_count} > MaxWords) begin
                        state_d = StErr;
                    end else if (hdr_count == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (word_full) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // Compare idx+1 against N so idx never has to hold 2^ADDR_W.
                if ((CountW + 1)'(idx_q) + 1'b1 == {1'b0, count_q}) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StData;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status and memory outputs decoded from the current state.
    always_comb begin
        byte_ready = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StData);
        busy       = byte_ready || (state_q == StWrite);
        mem_we     = (state_q == StWrite);
        done       = (state_q == StDone);
        err        = (state_q == StErr);
        cpu_hold   = (state_q != StDone);
        mem_addr   = idx_q;
        mem_wdata  = DATA_W'(asm_word);
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at stimulus, checked at mem_we.
module tb_prog_loader;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          wr_cnt  = 0;
    logic [9:0]  last_addr = '0;
    wr_t         exp_q[$];

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write pops one expected entry; an extra cycle of mem_we finds the queue empty.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_we === 1'b1) begin
            wr_t e;
            wr_cnt++;
            last_addr = mem_addr;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(mem_addr), 64'h3ff_ffff);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    // Called and returns on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (byte_ready) ok = 1'b1;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d, input int maxgap);
        exp_q.push_back('{addr: a, data: d});
        for (int k = 0; k < 4; k++) begin
            send_byte(d[8*k +: 8], (maxgap > 0) ? int'($urandom_range(32'(maxgap), 0)) : 0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        bit ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (done || err) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) check("end_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_we"},    64'(mem_we),     64'd0);
        check({tag, "_addr"},  64'(mem_addr),   64'd0);
        check({tag, "_wdata"}, 64'(mem_wdata),  64'd0);
        check({tag, "_busy"},  64'(busy),       64'd0);
        check({tag, "_done"},  64'(done),       64'd0);
        check({tag, "_err"},   64'(err),        64'd0);
        check({tag, "_hold"},  64'(cpu_hold),   64'd1);
    endtask

    initial begin
        int w0;
        rst = 1'b0; start = 1'b0; byte_in = '0; byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Three-word load.
        pulse_start();
        check("hdr0_busy", 64'(busy), 64'd1);
        check("hdr0_ready", 64'(byte_ready), 64'd1);
        w0 = wr_cnt;
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        load_word(10'd0, 32'h0403_0201, 0);
        load_word(10'd1, 32'h0807_0605, 0);
        load_word(10'd2, 32'h0C0B_0A09, 0);
        wait_end();
        check("t1_done", 64'(done), 64'd1);
        check("t1_hold", 64'(cpu_hold), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_writes", 64'(wr_cnt - w0), 64'd3);

        // Empty program goes straight to DONE.
        pulse_start();
        check("t2_restart_done", 64'(done), 64'd0);
        w0 = wr_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t2_done", 64'(done), 64'd1);
        check("t2_hold", 64'(cpu_hold), 64'd0);
        check("t2_writes", 64'(wr_cnt - w0), 64'd0);

        // Oversized count aborts.
        pulse_start();
        w0 = wr_cnt;
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check("t3_err", 64'(err), 64'd1);
        check("t3_hold", 64'(cpu_hold), 64'd1);
        check("t3_done", 64'(done), 64'd0);
        check("t3_ready", 64'(byte_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("t3_writes", 64'(wr_cnt - w0), 64'd0);
        pulse_start();
        check("t3_rehdr_err", 64'(err), 64'd0);
        check("t3_rehdr_ready", 64'(byte_ready), 64'd1);
        check("t3_rehdr_busy", 64'(busy), 64'd1);

        // Two words with random valid gaps; start mid-load must be ignored.
        w0 = wr_cnt;
        send_byte(8'h02, 2);
        send_byte(8'h00, 1);
        load_word(10'd0, $urandom, 3);
        pulse_start();
        check("t4_start_ignored", 64'(busy), 64'd1);
        load_word(10'd1, $urandom, 3);
        wait_end();
        check("t4_done", 64'(done), 64'd1);
        check("t4_writes", 64'(wr_cnt - w0), 64'd2);
        check("t4_queue", 64'(exp_q.size()), 64'd0);

        // Reset mid-word.
        pulse_start();
        w0 = wr_cnt;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b0;
        #1;
        check_reset_outputs("t5_inrst");
        @(negedge clk);
        rst = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'h55;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        check_reset_outputs("t5_post");
        check("t5_writes", 64'(wr_cnt - w0), 64'd0);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        load_word(10'd0, 32'hDEAD_BEEF, 1);
        wait_end();
        check("t5_fresh_done", 64'(done), 64'd1);
        check("t5_fresh_writes", 64'(wr_cnt - w0), 64'd1);

        // Full memory: 1024 words.
        pulse_start();
        w0 = wr_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 1024; i++) begin
            load_word(10'(i), 32'h1000_0000 + 32'(i) * 32'h0001_0003, 0);
        end
        wait_end();
        check("t6_done", 64'(done), 64'd1);
        check("t6_err", 64'(err), 64'd0);
        check("t6_writes", 64'(wr_cnt - w0), 64'd1024);
        check("t6_last_addr", 64'(last_addr), 64'd1023);
        check("t6_queue", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
